// File: rtl/macc_writeback_pkg.sv
// macc_writeback_pkg: shared default sizes and saturation bounds for the MACC writeback block.
package macc_writeback_pkg;
  localparam int DEF_IN_WIDTH   = 32;
  localparam int DEF_OUT_WIDTH  = 16;
  localparam int DEF_PACK_NUM   = 4;
  localparam int DEF_FIFO_DEPTH = 8;
  function automatic logic signed [63:0] sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction
endpackage

// File: rtl/macc_wb_fifo.sv
// macc_wb_fifo: registered word FIFO carrying a tile-end tag; head word is zero while empty.
module macc_wb_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  input  logic         din_last,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout,
  output logic         dout_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W:0] mem_q [DEPTH];
  logic [W:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign {dout_last, dout} = empty ? '0 : mem_q[rd_q];
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = {din_last, din};
    wr_d  = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d  = pop_ok ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/macc_writeback.sv
// macc_writeback: saturates MACC results, packs PACK_NUM lanes per word and queues words in a FIFO.
// Define MACC_WRITEBACK_RELU_EN to zero negative inputs before saturation.
module macc_writeback
  import macc_writeback_pkg::*;
#(
  parameter int IN_WIDTH   = DEF_IN_WIDTH,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int PACK_NUM   = DEF_PACK_NUM,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PACK_NUM*OUT_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          sat_flag,
  input  logic                          clear_flag
);
  localparam int LW = $clog2(PACK_NUM);
  localparam int WW = PACK_NUM * OUT_WIDTH;
  localparam logic signed [63:0] SMAX = sat_max(OUT_WIDTH);
  localparam logic signed [63:0] SMIN = sat_min(OUT_WIDTH);
  logic signed [IN_WIDTH-1:0] in_s;
  logic signed [63:0] x, clamped;
  logic [OUT_WIDTH-1:0] lane_val;
  logic [LW-1:0] lane_cnt_q, lane_cnt_d;
  logic [WW-1:0] pack_q, pack_d, word;
  logic sat_q, sat_d, sat, xfer, push, fifo_full, fifo_empty;
  assign in_s = in_data;
  assign xfer = in_valid && in_ready;
  assign push = xfer && (in_last || lane_cnt_q == LW'(PACK_NUM - 1));
  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign sat_flag  = sat_q;
  always_comb begin
`ifdef MACC_WRITEBACK_RELU_EN
    x = in_s[IN_WIDTH-1] ? '0 : 64'(in_s);
`else
    x = 64'(in_s);
`endif
    sat = x > SMAX || x < SMIN;
    clamped = x > SMAX ? SMAX : x < SMIN ? SMIN : x;
    lane_val = OUT_WIDTH'(clamped);
    word = pack_q;
    for (int i = 0; i < PACK_NUM; i++)
      if (lane_cnt_q == LW'(i)) word[i*OUT_WIDTH +: OUT_WIDTH] = lane_val;
    pack_d = push ? '0 : xfer ? word : pack_q;
    lane_cnt_d = push ? '0 : xfer ? lane_cnt_q + LW'(1) : lane_cnt_q;
    // A saturating transfer outranks a simultaneous clear.
    sat_d = (xfer && sat) ? 1'b1 : clear_flag ? 1'b0 : sat_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_cnt_q <= '0;
      pack_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      pack_q     <= pack_d;
      sat_q      <= sat_d;
    end
  end
  macc_wb_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (out_ready),
    .din       (word),
    .din_last  (in_last),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .dout      (out_data),
    .dout_last (out_last)
  );
endmodule

// File: tb/tb_macc_writeback.sv
// tb_macc_writeback: directed vectors with a queue scoreboard checked by an independent output monitor.
module tb_macc_writeback;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 1, clear_flag = 0;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_last, sat_flag;
  logic [63:0] out_data;
  logic [64:0] exp_q [$];
  int n_chk = 0, n_fail = 0;

  macc_writeback dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .sat_flag(sat_flag), .clear_flag(clear_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", {out_last, out_data});
      end else chk("out_word", {out_last, out_data}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] v, input logic l);
    int n = 0;
    in_valid = 1;
    in_data = v;
    in_last = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 65'(in_ready), 65'd1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic expect_word(input logic [63:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 65'(exp_q.size()), 65'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_out_valid", 65'(out_valid), 65'd0);
    chk("rst_out_data", {out_last, out_data}, 65'd0);
    chk("rst_sat_flag", 65'(sat_flag), 65'd0);
    chk("rst_in_ready", 65'(in_ready), 65'd1);

    expect_word(64'h0004_0003_0002_0001, 0);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    chk("valid_after_4th", 65'(out_valid), 65'd1);
    drain();

`ifdef MACC_WRITEBACK_RELU_EN
    expect_word(64'h0000_0000_0000_7FFF, 1);
`else
    expect_word(64'h0000_0000_8000_7FFF, 1);
`endif
    send(32767, 0); send(-32768, 1);
    drain();
    chk("boundary_no_sat", 65'(sat_flag), 65'd0);

`ifdef MACC_WRITEBACK_RELU_EN
    expect_word(64'h0000_0000_0000_7FFF, 1);
`else
    expect_word(64'h0000_0000_8000_7FFF, 1);
`endif
    send(70000, 0); send(-70000, 1);
    chk("sat_set", 65'(sat_flag), 65'd1);
    drain();
    clear_flag = 1;
    @(posedge clk);
    #1;
    clear_flag = 0;
    chk("sat_cleared", 65'(sat_flag), 65'd0);

    expect_word(64'h0000_0000_0000_7FFF, 1);
    clear_flag = 1;
    send(100000, 1);
    clear_flag = 0;
    chk("sat_set_wins", 65'(sat_flag), 65'd1);
    drain();
    clear_flag = 1;
    @(posedge clk);
    #1;
    clear_flag = 0;

    expect_word(64'h0000_0000_0006_0005, 1);
    send(5, 0); send(6, 1);
    drain();

    out_ready = 0;
    for (int w = 0; w < 8; w++)
      expect_word({16'(4*w+4), 16'(4*w+3), 16'(4*w+2), 16'(4*w+1)}, 0);
    for (int i = 0; i < 32; i++) begin
      if (i == 28) chk("ready_before_full", 65'(in_ready), 65'd1);
      send(32'(i + 1), 0);
    end
    chk("ready_drops_full", 65'(in_ready), 65'd0);
    in_valid = 1;
    in_data = 99;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready_low", 65'(in_ready), 65'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    out_ready = 1;
    drain();
    chk("ready_recovers", 65'(in_ready), 65'd1);

    send(7, 0); send(8, 0); send(9, 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    chk("midrst_out_valid", 65'(out_valid), 65'd0);
    chk("midrst_in_ready", 65'(in_ready), 65'd1);
    expect_word(64'h0028_001E_0014_000A, 0);
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    drain();

`ifdef MACC_WRITEBACK_RELU_EN
    expect_word(64'h0002_0000_0007_0000, 0);
`else
    expect_word(64'h0002_FFFF_0007_FFFB, 0);
`endif
    send(-5, 0); send(7, 0); send(-1, 0); send(2, 0);
    drain();
    chk("relu_sat_flag", 65'(sat_flag), 65'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", 65'(out_valid), 65'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
